rggen_bit_field_request_dispatcher: RTL and testbench
=====================================================

// Module: rggen_bit_field_request_dispatcher
// PURPOSE
//  Downstream consumer of a W1S/W0S request bit field. It takes the field's o_value
//  vector as pending requests and picks one per round-robin. The pick is issued to
//  hardware over a valid/ready handshake, and the block waits for completion. It then
//  pulses the matching bit on the field's i_clear input, so software doorbells are
//  serviced and self-clear.
// PARAMETERS
//  WIDTH          8    number of request bits (>=1)
//  TIMEOUT_CYCLES 256  max cycles waiting for i_done (>=1); used only with the macro
//  IDX_WIDTH      localparam = max(1, clog2(WIDTH))
// PORTS
//  i_clk      in   1          clock
//  i_rst      in   1          reset, synchronous, active-high
//  i_request  in   WIDTH      pending requests (field o_value)
//  o_clear    out  WIDTH      one-hot clear pulse (to field i_clear)
//  o_valid    out  1          dispatch request valid
//  o_index    out  IDX_WIDTH  index of dispatched bit
//  i_ready    in   1          downstream accepts dispatch
//  i_done     in   1          downstream completed the accepted dispatch
//  o_timeout  out  1          1-cycle pulse: dispatch abandoned on timeout
// BEHAVIOUR
//  - All state is sampled on posedge i_clk. Reset is synchronous and active-high:
//    FSM=IDLE, rr pointer=WIDTH-1 (bit 0 highest priority first), o_valid=0,
//    o_index=0, o_clear=0, o_timeout=0, counter=0.
//  - IDLE: if |i_request, latch the rr pick into o_index and go to ISSUE. o_valid
//    rises 1 cycle after the request is visible.
//  - Rr pick: the first set bit searching upward from pointer+1, wrapping at WIDTH-1 to 0.
//  - ISSUE: o_valid=1. o_index is held stable until o_valid&&i_ready; then go to WAIT_DONE.
//    i_done is ignored in ISSUE.
//  - WAIT_DONE: o_valid=0. On i_done go to CLEAR.
//  - CLEAR: o_clear=1<<o_index for exactly 1 cycle. The pointer takes o_index.
//    The next state is IDLE.
//  - The field clears on the same edge, so IDLE sees the updated vector; no dead cycle.
//  - Software re-set of the bit during the CLEAR cycle survives, because the field gives
//    set priority. That bit is then eligible again, but after the other pending bits.
//  - A request bit dropping while in ISSUE/WAIT_DONE does not abort the dispatch.
//  - Only one dispatch is outstanding at a time; o_clear is never multi-hot.
//  - Reset mid-operation returns to IDLE with no o_clear pulse. Requests still set in the
//    field are re-dispatched after reset.
//  - WIDTH=1: the pointer is constant, and the index is always 0.
// CONFIGURATION
//  RGGEN_REQUEST_DISPATCHER_TIMEOUT_EN
//   - defined: the counter clears on entry to WAIT_DONE and increments each cycle there.
//     If it reaches TIMEOUT_CYCLES-1 without i_done, go to CLEAR, and o_timeout=1 in the
//     CLEAR cycle alongside o_clear.
//     i_done on the expiry cycle wins: no timeout pulse.
//   - undefined: no counter; WAIT_DONE waits indefinitely; o_timeout is tied 0.
// STRUCTURE
//  - FSM state encodings (IDLE/ISSUE/WAIT_DONE/CLEAR) are localparams in this file.
//  - The clog2 helper function goes in the shared rggen include header. No package.
//  - Sub-module rggen_rr_picker (combinational): inputs request vector and pointer;
//    outputs found flag and index. It is reusable by other multi-source fields.
// TESTING
//  1 reset: assert i_rst 2 cycles with i_request=8'hFF -> o_valid=0, o_clear=0, o_timeout=0.
//    First grant after release is index 0.
//  2 single: i_request=8'h04, i_ready=1 -> o_valid in cycle+1 with o_index=2.
//    i_done 3 cycles later -> o_clear=8'h04 for 1 cycle, then IDLE.
//  3 fairness: i_request=8'h81, each bit re-set after its clear -> grant order 0,7,0,7.
//  4 backpressure: i_ready=0 for 5 cycles -> o_valid held 1, o_index stable.
//    i_ready=1 -> WAIT_DONE next cycle.
//  5 timeout: macro defined, TIMEOUT_CYCLES=4, no i_done -> o_clear + o_timeout 4 cycles
//    after the handshake. Macro undefined: no clear after 100 cycles, o_timeout=0.
//  6 reset in WAIT_DONE: i_request=8'h10 still set -> no o_clear. After reset, index 4
//    is re-dispatched.

Source files
------------

// File: rtl/rggen_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward from
// pointer+1, wrapping at WIDTH-1 back to 0. Reusable by any multi-source field.
module rggen_rr_picker #(
   parameter int WIDTH     = 8,
   parameter int IDX_WIDTH = 3
) (
   input  logic [WIDTH-1:0]     request,
   input  logic [IDX_WIDTH-1:0] pointer,
   output logic                 found,
   output logic [IDX_WIDTH-1:0] index
);

   logic [IDX_WIDTH-1:0] candidate;

   // The pointer itself is visited last, so the most recent grant has lowest priority.
   always_comb begin
      found     = 1'b0;
      index     = '0;
      candidate = '0;
      for (int offset = 1; offset <= WIDTH; offset++) begin
         candidate = IDX_WIDTH'((int'(pointer) + offset) % WIDTH);
         if (!found && request[candidate]) begin
            found = 1'b1;
            index = candidate;
         end
      end
   end

endmodule

// File: rtl/rggen_rtl_common.sv
// Shared helper functions for the rggen bit-field RTL.
// Included by the bit-field sources; the guard keeps one copy per compile.
`ifndef RGGEN_RTL_COMMON_SV
`define RGGEN_RTL_COMMON_SV

function automatic int rggen_clog2(input int value);
   int result;
   result = 0;
   while ((1 << result) < value) begin
      result++;
   end
   return result;
endfunction

`endif

// File: rtl/rggen_bit_field_request_dispatcher.sv
// Services a W1S/W0S request field one bit at a time: round-robin pick, valid/ready
// issue, wait for done, then a one-hot clear pulse. Optional RGGEN_REQUEST_DISPATCHER_TIMEOUT_EN.
`include "rggen_rtl_common.sv"

module rggen_bit_field_request_dispatcher #(
   parameter  int WIDTH          = 8,
   parameter  int TIMEOUT_CYCLES = 256,
   localparam int IDX_WIDTH      = (rggen_clog2(WIDTH) > 0) ? rggen_clog2(WIDTH) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [WIDTH-1:0]     i_request,
   output logic [WIDTH-1:0]     o_clear,
   output logic                 o_valid,
   output logic [IDX_WIDTH-1:0] o_index,
   input  logic                 i_ready,
   input  logic                 i_done,
   output logic                 o_timeout
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_CLEAR     = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      ISSUE     = ST_ISSUE,
      WAIT_DONE = ST_WAIT_DONE,
      CLEAR     = ST_CLEAR
   } state_e;

   state_e               state;
   logic [IDX_WIDTH-1:0] pointer;
   logic                 pick_found;
   logic [IDX_WIDTH-1:0] pick_index;
   logic                 expired;

   rggen_rr_picker #(
      .WIDTH     (WIDTH),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_picker (
      .request (i_request),
      .pointer (pointer),
      .found   (pick_found),
      .index   (pick_index)
   );

`ifdef RGGEN_REQUEST_DISPATCHER_TIMEOUT_EN
   localparam int                   CNT_WIDTH = (rggen_clog2(TIMEOUT_CYCLES) > 0) ? rggen_clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [CNT_WIDTH-1:0] wait_count;

   assign expired = (wait_count == CNT_LAST);
`else
   assign expired   = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // Pointer starts at WIDTH-1 so bit 0 wins the first pick after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         pointer <= IDX_WIDTH'(WIDTH - 1);
         o_valid <= 1'b0;
         o_index <= '0;
         o_clear <= '0;
`ifdef RGGEN_REQUEST_DISPATCHER_TIMEOUT_EN
         o_timeout  <= 1'b0;
         wait_count <= '0;
`endif
      end else begin
         o_clear <= '0;
`ifdef RGGEN_REQUEST_DISPATCHER_TIMEOUT_EN
         o_timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_found) begin
                  o_index <= pick_index;
                  o_valid <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (o_valid && i_ready) begin
                  o_valid <= 1'b0;
                  state   <= WAIT_DONE;
`ifdef RGGEN_REQUEST_DISPATCHER_TIMEOUT_EN
                  wait_count <= '0;
`endif
               end
            end
            WAIT_DONE: begin
               // A done arriving on the expiry cycle completes normally, without the timeout flag.
               if (i_done || expired) begin
                  o_clear <= WIDTH'(1) << o_index;
                  pointer <= o_index;
                  state   <= CLEAR;
`ifdef RGGEN_REQUEST_DISPATCHER_TIMEOUT_EN
                  o_timeout <= !i_done;
`endif
               end
`ifdef RGGEN_REQUEST_DISPATCHER_TIMEOUT_EN
               else begin
                  wait_count <= wait_count + CNT_WIDTH'(1);
               end
`endif
            end
            CLEAR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rggen_bit_field_request_dispatcher.sv
// Self-checking bench for rggen_bit_field_request_dispatcher with a model of the
// W1S request field (set priority over clear) feeding i_request.
module tb_rggen_bit_field_request_dispatcher;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] swSet;
   logic [7:0] fieldValue = 8'h00;
   logic [7:0] clear;
   logic       valid;
   logic [2:0] index;
   logic       ready;
   logic       done;
   logic       timeout;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [2:0] expQ[$];

   typedef struct {
      logic [7:0] setMask;
      int         readyDelay;
      int         doneDelay;
      bit         reSet;
      logic [2:0] expIndex;
   } vector_t;

   vector_t vectors[13];

   always #5 clk = ~clk;

   // Request field: software set wins over the dispatcher's clear on the same edge.
   always @(posedge clk) begin
      fieldValue <= (fieldValue & ~clear) | swSet;
   end

   rggen_bit_field_request_dispatcher #(
      .WIDTH          (8),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_request (fieldValue),
      .o_clear   (clear),
      .o_valid   (valid),
      .o_index   (index),
      .i_ready   (ready),
      .i_done    (done),
      .o_timeout (timeout)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic waitValid(output logic [2:0] grantIdx);
      logic [2:0] expIdx;
      int waited;
      waited = 0;
      while (!valid && waited < 20) begin
         tick();
         waited++;
      end
      checkOutput("valid_arrives", {31'd0, valid}, 32'd1);
      expIdx = 3'd0;
      if (expQ.size() > 0) begin
         expIdx = expQ.pop_front();
      end
      checkOutput("grant_index", {29'd0, index}, {29'd0, expIdx});
      grantIdx = expIdx;
   endtask

   task automatic holdIssue(input int delay, input logic [2:0] grantIdx);
      ready = 1'b0;
      done  = (delay > 0);
      for (int k = 0; k < delay; k++) begin
         tick();
         checkOutput("bp_valid_held", {31'd0, valid}, 32'd1);
         checkOutput("bp_index_stable", {29'd0, index}, {29'd0, grantIdx});
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      done  = 1'b0;
      checkOutput("valid_drops_after_handshake", {31'd0, valid}, 32'd0);
   endtask

   task automatic completeDispatch(input int doneDelay, input logic [2:0] grantIdx, input bit reSet);
      logic [7:0] expClear;
      expClear = 8'h01 << grantIdx;
      for (int k = 0; k < doneDelay; k++) begin
         checkOutput("no_early_clear", {24'd0, clear}, 32'd0);
         tick();
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checkOutput("clear_pulse", {24'd0, clear}, {24'd0, expClear});
      checkOutput("no_timeout_on_done", {31'd0, timeout}, 32'd0);
      if (reSet) begin
         swSet = expClear;
      end
      tick();
      swSet = 8'h00;
      checkOutput("clear_one_cycle", {24'd0, clear}, 32'd0);
   endtask

   task automatic applyStimulus(input vector_t v);
      logic [2:0] grantIdx;
      expQ.push_back(v.expIndex);
      if (v.setMask != 8'h00) begin
         swSet = v.setMask;
         tick();
         swSet = 8'h00;
      end
      waitValid(grantIdx);
      holdIssue(v.readyDelay, grantIdx);
      completeDispatch(v.doneDelay, grantIdx, v.reSet);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0] grantIdx;
      int badCycles;

      // Field fully set before release: grants must walk 0..7, then fairness and backpressure.
      for (int i = 0; i < 8; i++) begin
         vectors[i] = '{setMask: 8'h00, readyDelay: i % 3, doneDelay: 1 + i % 3, reSet: 1'b0, expIndex: 3'(i)};
      end
      vectors[8]  = '{setMask: 8'h81, readyDelay: 1, doneDelay: 2, reSet: 1'b1, expIndex: 3'd0};
      vectors[9]  = '{setMask: 8'h00, readyDelay: 1, doneDelay: 2, reSet: 1'b1, expIndex: 3'd7};
      vectors[10] = '{setMask: 8'h00, readyDelay: 0, doneDelay: 2, reSet: 1'b0, expIndex: 3'd0};
      vectors[11] = '{setMask: 8'h00, readyDelay: 0, doneDelay: 2, reSet: 1'b0, expIndex: 3'd7};
      vectors[12] = '{setMask: 8'h20, readyDelay: 5, doneDelay: 1, reSet: 1'b0, expIndex: 3'd5};

      rst   = 1'b1;
      swSet = 8'hFF;
      ready = 1'b0;
      done  = 1'b0;
      tick();
      swSet = 8'h00;
      tick();
      checkOutput("reset_valid", {31'd0, valid}, 32'd0);
      checkOutput("reset_clear", {24'd0, clear}, 32'd0);
      checkOutput("reset_timeout", {31'd0, timeout}, 32'd0);
      checkOutput("reset_index", {29'd0, index}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vectors[i]);
      end

      // Single request: o_valid one cycle after the request becomes visible.
      expQ.push_back(3'd2);
      swSet = 8'h04;
      tick();
      swSet = 8'h00;
      checkOutput("single_valid_not_yet", {31'd0, valid}, 32'd0);
      tick();
      checkOutput("single_valid_rise", {31'd0, valid}, 32'd1);
      waitValid(grantIdx);
      holdIssue(0, grantIdx);
      completeDispatch(3, grantIdx, 1'b0);
      tick();
      checkOutput("single_back_idle", {31'd0, valid}, 32'd0);

`ifdef RGGEN_REQUEST_DISPATCHER_TIMEOUT_EN
      // No done: clear plus timeout four cycles after the handshake.
      expQ.push_back(3'd3);
      swSet = 8'h08;
      tick();
      swSet = 8'h00;
      waitValid(grantIdx);
      holdIssue(0, grantIdx);
      for (int k = 0; k < 4; k++) begin
         checkOutput("timeout_not_early", {24'd0, clear}, 32'd0);
         tick();
      end
      checkOutput("timeout_clear", {24'd0, clear}, 32'h08);
      checkOutput("timeout_pulse", {31'd0, timeout}, 32'd1);
      tick();
      checkOutput("timeout_pulse_ends", {31'd0, timeout}, 32'd0);

      // Done on the expiry cycle wins: clear without timeout.
      expQ.push_back(3'd6);
      swSet = 8'h40;
      tick();
      swSet = 8'h00;
      waitValid(grantIdx);
      holdIssue(0, grantIdx);
      completeDispatch(3, grantIdx, 1'b0);
`else
      // Without the timeout feature the dispatcher waits for done indefinitely.
      expQ.push_back(3'd3);
      swSet = 8'h08;
      tick();
      swSet = 8'h00;
      waitValid(grantIdx);
      holdIssue(0, grantIdx);
      badCycles = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (clear !== 8'h00 || timeout !== 1'b0) begin
            badCycles++;
         end
      end
      checkOutput("no_clear_without_done", badCycles, 32'd0);
      completeDispatch(0, grantIdx, 1'b0);
`endif

      // Reset while waiting for done: no clear, and the still-set bit is re-dispatched.
      expQ.push_back(3'd4);
      swSet = 8'h10;
      tick();
      swSet = 8'h00;
      waitValid(grantIdx);
      holdIssue(0, grantIdx);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("rst_wait_no_clear_a", {24'd0, clear}, 32'd0);
      checkOutput("rst_wait_valid_low", {31'd0, valid}, 32'd0);
      tick();
      checkOutput("rst_wait_no_clear_b", {24'd0, clear}, 32'd0);
      checkOutput("rst_field_kept", {24'd0, fieldValue}, 32'h10);
      rst = 1'b0;
      expQ.push_back(3'd4);
      waitValid(grantIdx);
      holdIssue(0, grantIdx);
      completeDispatch(1, grantIdx, 1'b0);

      checkOutput("field_drained", {24'd0, fieldValue}, 32'd0);
      checkOutput("scoreboard_empty", expQ.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
